// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory access stage:
//   - FSM state encoding used by mem_access
//   - funct3 encodings for loads and stores
//   - default abort limit for a memory access
//   - helpers that decode legality, byte lanes and store-data replication
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Load encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store encodings (share values with the signed loads)
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int TIMEOUT_DEFAULT = 255;

  // Returns 1 when the funct3/alignment pair is a legal access. Stores only
  // know SB/SH/SW; loads additionally accept the unsigned variants.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr);
    logic ok;
    ok = 1'b0;
    case (funct3)
      LB:      ok = 1'b1;                    // also SB
      LH:      ok = !addr[0];                // also SH
      LW:      ok = (addr == 2'b00);         // also SW
      LBU:     ok = !is_store;
      LHU:     ok = !is_store && !addr[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte-lane mask from the access size (funct3[1:0]) and the byte offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] addr);
    logic [3:0] mask;
    case (size)
      2'b00:   mask = 4'b0001 << addr;
      2'b01:   mask = 4'b0011 << addr;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Replicate narrow store data across all lanes so the memory can pick
  // whichever lane the byte enables select.
  function automatic logic [31:0] store_data(input logic [1:0]  size,
                                             input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_load_formatter.sv
// ---------------------------------------------------------------------------
// load_formatter
// Purely combinational load-result formatting: selects the addressed byte or
// halfword from the read word and sign- or zero-extends it.
// Ports:
//   rdata  [31:0] in  - word returned by the data memory
//   addr   [1:0]  in  - byte offset of the access
//   funct3 [2:0]  in  - load type (LB/LH/LW/LBU/LHU)
//   data   [31:0] out - formatted load result
// ---------------------------------------------------------------------------
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every signal written in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_byte = rdata[7:0];
    case (addr)
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      2'd3:    w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    // Halfword accesses are 2-byte aligned, so only addr[1] picks the half.
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      LB:      data = {{24{w_byte[7]}}, w_byte};
      LH:      data = {{16{w_half[15]}}, w_half};
      LBU:     data = {24'd0, w_byte};
      LHU:     data = {16'd0, w_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
// Pipeline MEM stage front end: turns a load/store request from the EX/MEM
// register into a registered data-memory bus transaction, stalls upstream
// while it runs, formats the load result and aborts after TIMEOUT cycles.
// Ports:
//   clock, reset                 in  - clock, synchronous active-high reset
//   MEM_MemRead, MEM_MemWrite    in  - access request (write wins if both)
//   MEM_funct3 [2:0]             in  - access size/sign
//   Address, Writedata [31:0]    in  - byte address, store data
//   dmem_req, dmem_we            out - registered bus request / write enable
//   dmem_addr, dmem_wdata [31:0] out - registered word address / store data
//   dmem_be [3:0]                out - registered byte enables
//   dmem_ready, dmem_rdata       in  - completion strobe, read word
//   Readdata [31:0]              out - registered formatted load result
//   mem_stall                    out - combinational upstream hold
//   mem_fault                    out - combinational illegal/misaligned flag
//   bus_error                    out - registered one-cycle timeout pulse
// ---------------------------------------------------------------------------
module mem_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] Address,
  input  logic [31:0] Writedata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] Readdata,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic        bus_error
);

  // The counter only has to reach TIMEOUT-1.
  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             r_state;
  logic               r_req;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic [31:0]        r_rdata;
  logic               r_bus_error;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_lane;
  logic [2:0]         r_funct3;

  logic               w_request;
  logic               w_legal;
  logic               w_start;
  logic [31:0]        w_load_data;

  assign w_request = MEM_MemRead | MEM_MemWrite;
  // A simultaneous read+write is decoded as a store.
  assign w_legal   = access_legal(MEM_MemWrite, MEM_funct3, Address[1:0]);
  assign w_start   = w_request & w_legal;

  assign mem_fault = w_request & ~w_legal;
  // Upstream must hold from the cycle the request is seen until DONE.
  assign mem_stall = (r_state == ACCESS) | ((r_state == IDLE) & w_start);

  // Lane and type are captured with the request so the formatter does not
  // depend on the upstream register staying frozen.
  load_formatter u_load_formatter (
    .rdata  (dmem_rdata),
    .addr   (r_lane),
    .funct3 (r_funct3),
    .data   (w_load_data)
  );

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rdata     <= '0;
      r_bus_error <= 1'b0;
      r_cnt       <= '0;
      r_lane      <= '0;
      r_funct3    <= '0;
    end else begin
      r_bus_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_req    <= 1'b1;
            r_we     <= MEM_MemWrite;
            r_addr   <= {Address[31:2], 2'b00};
            r_wdata  <= MEM_MemWrite ? store_data(MEM_funct3[1:0], Writedata) : '0;
            r_be     <= lane_mask(MEM_funct3[1:0], Address[1:0]);
            r_lane   <= Address[1:0];
            r_funct3 <= MEM_funct3;
            r_cnt    <= '0;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (dmem_ready) begin
            r_req <= 1'b0;
            if (!r_we) begin
              r_rdata <= w_load_data;
            end
            r_state <= DONE;
          end else if (r_cnt == CNT_LAST) begin
            // Abort: release the bus, return a zero result, flag the error.
            r_req       <= 1'b0;
            r_rdata     <= '0;
            r_bus_error <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;
  assign Readdata   = r_rdata;
  assign bus_error  = r_bus_error;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles spent waiting for dmem_ready before the access is aborted.
REQ-002 The block SHALL have port clock, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, meaning reset, which is synchronous and active-high.
REQ-004 The block SHALL have ports MEM_MemRead and MEM_MemWrite, inputs, 1 bit each, meaning the access request from the EX/MEM register.
REQ-005 The block SHALL have port MEM_funct3, input, 3 bits, meaning the access size and sign (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
REQ-006 The block SHALL have ports Address and Writedata, inputs, 32 bits each, meaning the byte address and the store data.
REQ-007 The block SHALL have ports dmem_req, dmem_we, dmem_addr[31:0], dmem_wdata[31:0] and dmem_be[3:0], all outputs, meaning the registered data-memory bus; dmem_addr is word-aligned.
REQ-008 The block SHALL have ports dmem_ready (input, 1 bit) and dmem_rdata (input, 32 bits), meaning the memory completion strobe and the read word.
REQ-009 The block SHALL have port Readdata, output, 32 bits, meaning the formatted load result, registered.
REQ-010 The block SHALL have port mem_stall, output, 1 bit, combinational, meaning upstream registers must hold while it is high.
REQ-011 The block SHALL have ports mem_fault and bus_error, outputs, 1 bit each, meaning an illegal/misaligned access (combinational) and a timeout (registered, one-cycle pulse).

Function
REQ-012 The FSM SHALL have the states IDLE, ACCESS and DONE.
REQ-013 In IDLE, a legal request SHALL keep mem_stall=1, and the next edge SHALL load the bus registers, set dmem_req=1 and move to ACCESS.
REQ-014 In ACCESS, mem_stall SHALL be 1 and the bus outputs SHALL hold stable until the cycle in which dmem_ready=1.
REQ-015 On dmem_ready=1 in ACCESS, the next edge SHALL clear dmem_req, register Readdata (loads only) and move to DONE.
REQ-016 In DONE, mem_stall SHALL be 0 for exactly one cycle, and the state SHALL then return to IDLE unconditionally.
REQ-017 Minimum access latency SHALL be 3 cycles, from request seen to pipeline release.
REQ-018 If MEM_MemWrite and MEM_MemRead are both high, the write SHALL take priority: dmem_we=1 and Readdata is unchanged.
REQ-019 Stores SHALL use byte lanes dmem_be = SB 0001<<A[1:0], SH 0011<<A[1:0], SW 1111.
REQ-020 Stores SHALL replicate write data across lanes: SB {4{b}}, SH {2{h}}.
REQ-021 Loads SHALL select the lane from Address[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-022 mem_fault SHALL be asserted, with no request, no stall and the state remaining IDLE, for:
  - a halfword access with A[0]=1;
  - a word access with A[1:0]≠00;
  - a load with funct3 in {011, 110, 111};
  - a store with funct3 ≥ 011.
REQ-023 A cycle counter SHALL count cycles spent in ACCESS, and SHALL be cleared on ACCESS entry.
REQ-024 When the counter reaches TIMEOUT-1 without dmem_ready, the next edge SHALL:
  - drop dmem_req;
  - set Readdata to 0;
  - pulse bus_error for one cycle;
  - enter DONE.
REQ-025 dmem_ready in IDLE or DONE SHALL be ignored.
REQ-026 With no request, Readdata SHALL hold its last value.

Reset
REQ-027 Reset SHALL force the following at the next edge: state IDLE; dmem_req, dmem_we and bus_error 0; dmem_addr, dmem_wdata, dmem_be and Readdata 0; counter 0.
REQ-028 Reset asserted mid-ACCESS SHALL abandon the transaction; dmem_req SHALL be 0 after that edge, and a late dmem_ready SHALL be ignored.

Structure
REQ-029 Package mem_pkg SHALL hold the FSM state encoding, the funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW, and the TIMEOUT default.
REQ-030 Lane selection and sign/zero extension SHALL live in one combinational sub-module, load_formatter (inputs: rdata, addr[1:0], funct3; output: 32-bit data).

Verification
REQ-031 LB at 0x1003 with rdata 0x80FF_1234 and ready on the first ACCESS cycle -> Readdata 0xFFFFFF80, mem_stall high for 2 cycles, dmem_addr 0x1000.
REQ-032 SH at 0x2002 with Writedata 0x0000_ABCD -> dmem_be 1100, dmem_wdata 0xABCD_ABCD, dmem_we 1.
REQ-033 LW at 0x3001 -> mem_fault 1, dmem_req never asserted, mem_stall 0.
REQ-034 LHU at 0x4002 with ready delayed 5 cycles and rdata 0xBEEF_0000 -> bus outputs stable for the whole wait, Readdata 0x0000BEEF.
REQ-035 LW with dmem_ready never asserted and TIMEOUT=4 -> bus_error pulse after 4 ACCESS cycles, Readdata 0, then DONE and IDLE.
REQ-036 Reset on the 2nd ACCESS cycle, then dmem_ready one cycle later -> state IDLE, dmem_req 0, Readdata 0, bus_error 0.
